// File: rtl/test_io_mux.sv
`default_nettype none
// ============================================================================
// Module   : test_io_mux
// Purpose  : Runtime-configurable router from debug taps to test header pins,
//            with per-channel pass/stretch/divide/constant modes and counters.
// Revision : 1.0 - initial release
// ============================================================================
module test_io_mux #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 8,
    parameter int SEL_W = 3,
    parameter int CH_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  test_in,
    input  logic             cfg_wr,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [1:0]       cfg_mode,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [15:0]      cfg_arg,
    output logic             cfg_ack,
    output logic             cfg_err,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [N_OUT-1:0] test_out
);

    localparam logic [1:0] c_MODE_PASS    = 2'd0;
    localparam logic [1:0] c_MODE_STRETCH = 2'd1;
    localparam logic [1:0] c_MODE_DIV     = 2'd2;
    localparam logic [1:0] c_MODE_CONST   = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [N_IN-1:0]  r_s1, r_s2, r_s3;
    logic [N_IN-1:0]  w_rise;

    logic [1:0]       r_mode [N_OUT];
    logic [SEL_W-1:0] r_sel  [N_OUT];
    logic [15:0]      r_arg  [N_OUT];
    logic [15:0]      r_scnt [N_OUT];
    logic [15:0]      r_dcnt [N_OUT];
    logic [CNT_W-1:0] r_cnt  [N_OUT];
    logic [N_OUT-1:0] r_tog;
    logic [N_OUT-1:0] r_out;

    logic             r_ack, r_err;
    logic [CNT_W-1:0] r_rd;

    logic [31:0]      w_ch_ext;
    logic [31:0]      w_rd_ext;
    logic             w_ch_ok;
    logic             w_acc;
    logic [N_OUT-1:0] w_wr_hit;
    logic [N_OUT-1:0] w_src;
    logic [N_OUT-1:0] w_edge;
    logic [CNT_W-1:0] w_rd;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_ch_ext = 32'(cfg_ch);
    assign w_rd_ext = 32'(rd_ch);

    // Source selection is a compare-based mux so an out-of-range select
    // naturally yields a constant-0 source with no edges.
    always_comb begin
        w_ch_ok  = (w_ch_ext < 32'(N_OUT));
        w_acc    = cfg_wr & w_ch_ok;
        w_wr_hit = '0;
        w_src    = '0;
        w_edge   = '0;
        w_rd     = '0;
        for (int c = 0; c < N_OUT; c++) begin
            if (w_acc && (w_ch_ext == 32'(c))) begin
                w_wr_hit[c] = 1'b1;
            end
            for (int k = 0; k < N_IN; k++) begin
                if (32'(r_sel[c]) == 32'(k)) begin
                    w_src[c]  = r_s2[k];
                    w_edge[c] = w_rise[k];
                end
            end
            if (w_rd_ext == 32'(c)) begin
                w_rd = r_cnt[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_s3  <= '0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_rd  <= '0;
            r_tog <= '0;
            r_out <= '0;
            for (int c = 0; c < N_OUT; c++) begin
                r_mode[c] <= c_MODE_PASS;
                r_sel[c]  <= SEL_W'(c % N_IN);
                r_arg[c]  <= '0;
                r_scnt[c] <= '0;
                r_dcnt[c] <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            r_s1  <= test_in;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_ack <= w_acc;
            r_err <= cfg_wr & ~w_ch_ok;
            r_rd  <= w_rd;
            for (int c = 0; c < N_OUT; c++) begin
                // An accepted write takes priority over a same-cycle edge.
                if (w_wr_hit[c]) begin
                    r_mode[c] <= cfg_mode;
                    r_sel[c]  <= cfg_sel;
                    r_arg[c]  <= cfg_arg;
                    r_scnt[c] <= '0;
                    r_dcnt[c] <= '0;
                    r_cnt[c]  <= '0;
                    r_tog[c]  <= 1'b0;
                    r_out[c]  <= 1'b0;
                end else begin
                    if (w_edge[c] && (r_cnt[c] != c_CNT_MAX)) begin
                        r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                    end
                    case (r_mode[c])
                        c_MODE_PASS: begin
                            r_out[c] <= w_src[c];
                        end
                        c_MODE_STRETCH: begin
                            if (w_edge[c]) begin
                                r_scnt[c] <= r_arg[c];
                                r_out[c]  <= 1'b1;
                            end else if (r_scnt[c] != 16'd0) begin
                                r_scnt[c] <= r_scnt[c] - 16'd1;
                                r_out[c]  <= 1'b1;
                            end else begin
                                r_out[c]  <= 1'b0;
                            end
                        end
                        c_MODE_DIV: begin
                            if (w_edge[c] && (r_dcnt[c] == r_arg[c])) begin
                                r_dcnt[c] <= 16'd0;
                                r_tog[c]  <= ~r_tog[c];
                                r_out[c]  <= ~r_tog[c];
                            end else begin
                                if (w_edge[c]) begin
                                    r_dcnt[c] <= r_dcnt[c] + 16'd1;
                                end
                                r_out[c] <= r_tog[c];
                            end
                        end
                        c_MODE_CONST: begin
                            r_out[c] <= r_arg[c][0];
                        end
                        default: begin
                            r_out[c] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign cfg_ack  = r_ack;
    assign cfg_err  = r_err;
    assign rd_cnt   = r_rd;
    assign test_out = r_out;

endmodule
`default_nettype wire
